// File: rtl/batalha_pkg.sv
// Shared constants, FSM state encoding and helpers for the battleship shot-resolution datapath.
package batalha_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned WORD_W = 64;
  localparam int unsigned COL_W  = 6;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned HITS_W = 7;

  // Controller timing: arbitration latency, read latency, write strobe width.
  localparam int unsigned GRANT_WAIT = 2;
  localparam int unsigned READ_LAT   = 2;
  localparam int unsigned WRITE_HOLD = 1;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Full-width mask is formed before inversion so column 63 is not truncated.
  function automatic logic [WORD_W-1:0] clear_bit(input logic [WORD_W-1:0] w,
                                                  input logic [COL_W-1:0]  c);
    return w & ~(WORD_W'(1) << c);
  endfunction

endpackage

// File: rtl/colisor_tiro.sv
// Shot resolution: claims the controller collision path, reads a board row, clears a hit cell.
// Optional per-player hit counters are enabled with the HIT_COUNT_EN macro.
module colisor_tiro
  import batalha_pkg::*;
(
  input  logic              clk,
  input  logic              resetGeral,
  input  logic              shot_valid,
  output logic              shot_ready,
  input  logic              shot_player,
  input  logic [ADDR_W-1:0] shot_row,
  input  logic [COL_W-1:0]  shot_col,
  output logic              res_valid,
  output logic              res_hit,
  output logic              res_row_empty,
  output logic              readyColisor,
  output logic              jogadorColisor,
  output logic [ADDR_W-1:0] colisor_addr,
  output logic [WORD_W-1:0] colisor_data,
  output logic              colisor_wrep1,
  output logic              colisor_wrep2,
  input  logic [WORD_W-1:0] dataReadColisor
`ifdef HIT_COUNT_EN
  ,
  output logic [HITS_W-1:0] hits_p1,
  output logic [HITS_W-1:0] hits_p2
`endif
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                player_q, player_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                hit_q, hit_d;

  logic                shot_ready_q, shot_ready_d;
  logic                res_valid_q, res_valid_d;
  logic                res_hit_q, res_hit_d;
  logic                res_empty_q, res_empty_d;
  logic                ready_q, ready_d;
  logic                jog_q, jog_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic                wr1_q, wr1_d;
  logic                wr2_q, wr2_d;

`ifdef HIT_COUNT_EN
  logic [HITS_W-1:0]   hits_p1_q, hits_p1_d;
  logic [HITS_W-1:0]   hits_p2_q, hits_p2_d;
`endif

  always_ff @(posedge clk) begin
    if (resetGeral) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      player_q     <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      word_q       <= '0;
      hit_q        <= 1'b0;
      shot_ready_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_hit_q    <= 1'b0;
      res_empty_q  <= 1'b0;
      ready_q      <= 1'b0;
      jog_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      wr1_q        <= 1'b0;
      wr2_q        <= 1'b0;
`ifdef HIT_COUNT_EN
      hits_p1_q    <= '0;
      hits_p2_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      player_q     <= player_d;
      row_q        <= row_d;
      col_q        <= col_d;
      word_q       <= word_d;
      hit_q        <= hit_d;
      shot_ready_q <= shot_ready_d;
      res_valid_q  <= res_valid_d;
      res_hit_q    <= res_hit_d;
      res_empty_q  <= res_empty_d;
      ready_q      <= ready_d;
      jog_q        <= jog_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wr1_q        <= wr1_d;
      wr2_q        <= wr2_d;
`ifdef HIT_COUNT_EN
      hits_p1_q    <= hits_p1_d;
      hits_p2_q    <= hits_p2_d;
`endif
    end
  end

  // Next state plus registered outputs derived from the state being entered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    player_d = player_q;
    row_d    = row_q;
    col_d    = col_q;
    word_d   = word_q;
    hit_d    = hit_q;

    unique case (state_q)
      IDLE: begin
        if (shot_valid && shot_ready_q) begin
          player_d = shot_player;
          row_d    = shot_row;
          col_d    = shot_col;
          state_d  = REQ;
          cnt_d    = CNT_W'(GRANT_WAIT - 1);
        end
      end
      REQ: begin
        if (cnt_q == '0) begin
          state_d = READ;
          cnt_d   = CNT_W'(READ_LAT - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      READ: begin
        if (cnt_q == '0) begin
          hit_d = dataReadColisor[col_q];
          if (dataReadColisor[col_q]) begin
            word_d  = clear_bit(dataReadColisor, col_q);
            state_d = WRITE;
            cnt_d   = CNT_W'(WRITE_HOLD - 1);
          end else begin
            word_d  = dataReadColisor;
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WRITE: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // word_q holds the written-back row on a hit and the raw row on a miss.
    shot_ready_d = (state_d == IDLE);
    ready_d      = (state_d == REQ) || (state_d == READ) || (state_d == WRITE);
    jog_d        = player_d;
    addr_d       = row_d;
    data_d       = (state_d == WRITE) ? word_d : data_q;
    wr1_d        = (state_d == WRITE) && (player_d == P1);
    wr2_d        = (state_d == WRITE) && (player_d == P2);
    res_valid_d  = (state_d == DONE);
    res_hit_d    = (state_d == DONE) && hit_d;
    res_empty_d  = (state_d == DONE) && (word_d == '0);
  end

`ifdef HIT_COUNT_EN
  // Saturating hit tally, bumped while the hit result is being reported.
  always_comb begin
    hits_p1_d = hits_p1_q;
    hits_p2_d = hits_p2_q;
    if ((state_q == DONE) && res_hit_q) begin
      if ((player_q == P1) && (hits_p1_q != {HITS_W{1'b1}})) begin
        hits_p1_d = hits_p1_q + HITS_W'(1);
      end
      if ((player_q == P2) && (hits_p2_q != {HITS_W{1'b1}})) begin
        hits_p2_d = hits_p2_q + HITS_W'(1);
      end
    end
  end

  assign hits_p1 = hits_p1_q;
  assign hits_p2 = hits_p2_q;
`endif

  assign shot_ready     = shot_ready_q;
  assign res_valid      = res_valid_q;
  assign res_hit        = res_hit_q;
  assign res_row_empty  = res_empty_q;
  assign readyColisor   = ready_q;
  assign jogadorColisor = jog_q;
  assign colisor_addr   = addr_q;
  assign colisor_data   = data_q;
  assign colisor_wrep1  = wr1_q;
  assign colisor_wrep2  = wr2_q;

endmodule

// File: tb/tb_colisor_tiro.sv
// Directed self-checking bench for colisor_tiro with a simple two-board memory model.
module tb_colisor_tiro;
  import batalha_pkg::*;

  logic              clk = 1'b0;
  logic              resetGeral;
  logic              shot_valid;
  logic              shot_ready;
  logic              shot_player;
  logic [4:0]        shot_row;
  logic [5:0]        shot_col;
  logic              res_valid;
  logic              res_hit;
  logic              res_row_empty;
  logic              readyColisor;
  logic              jogadorColisor;
  logic [4:0]        colisor_addr;
  logic [63:0]       colisor_data;
  logic              colisor_wrep1;
  logic              colisor_wrep2;
  logic [63:0]       dataReadColisor;
`ifdef HIT_COUNT_EN
  logic [6:0]        hits_p1;
  logic [6:0]        hits_p2;
`endif

  int total = 0;
  int bad   = 0;

  logic [63:0] mem0 [32];
  logic [63:0] mem1 [32];

  always #5 clk = ~clk;

  colisor_tiro dut (
    .clk            (clk),
    .resetGeral     (resetGeral),
    .shot_valid     (shot_valid),
    .shot_ready     (shot_ready),
    .shot_player    (shot_player),
    .shot_row       (shot_row),
    .shot_col       (shot_col),
    .res_valid      (res_valid),
    .res_hit        (res_hit),
    .res_row_empty  (res_row_empty),
    .readyColisor   (readyColisor),
    .jogadorColisor (jogadorColisor),
    .colisor_addr   (colisor_addr),
    .colisor_data   (colisor_data),
    .colisor_wrep1  (colisor_wrep1),
    .colisor_wrep2  (colisor_wrep2),
    .dataReadColisor(dataReadColisor)
`ifdef HIT_COUNT_EN
    ,
    .hits_p1        (hits_p1),
    .hits_p2        (hits_p2)
`endif
  );

  assign dataReadColisor = jogadorColisor ? mem1[colisor_addr] : mem0[colisor_addr];

  // Board memories: preloaded on reset, written by the DUT strobes.
  always @(posedge clk) begin
    if (resetGeral) begin
      for (int i = 0; i < 32; i++) begin
        mem0[i] <= 64'h0;
        mem1[i] <= 64'h0;
      end
      mem0[4]  <= 64'h0000_0000_0000_00F0;
      mem0[7]  <= 64'h0000_0000_0000_0001;
      mem1[0]  <= 64'h0000_0000_0000_0001;
      mem1[31] <= 64'h8000_0000_0000_0000;
    end else begin
      if (colisor_wrep1) mem0[colisor_addr] <= colisor_data;
      if (colisor_wrep2) mem1[colisor_addr] <= colisor_data;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!shot_ready && guard < 20) begin
      tick();
      guard++;
    end
    chk("ready_before_shot", 64'(shot_ready), 64'h1);
  endtask

  // Issues one shot and observes the nine cycles after the accept edge.
  task automatic run_shot(input logic p, input logic [4:0] r, input logic [5:0] c,
                          output int rv_k, output int rv_n, output int rdy_n,
                          output int w1_n, output int w2_n, output logic [63:0] wd,
                          output logic [4:0] wa, output logic hit, output logic emp);
    rv_k = -1; rv_n = 0; rdy_n = 0; w1_n = 0; w2_n = 0;
    wd = '0; wa = '0; hit = 1'b0; emp = 1'b0;
    wait_ready();
    shot_valid = 1'b1; shot_player = p; shot_row = r; shot_col = c;
    tick();
    shot_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (readyColisor) rdy_n++;
      if (colisor_wrep1) begin w1_n++; wd = colisor_data; wa = colisor_addr; end
      if (colisor_wrep2) begin w2_n++; wd = colisor_data; wa = colisor_addr; end
      if (res_valid) begin rv_n++; rv_k = k; hit = res_hit; emp = res_row_empty; end
      tick();
    end
  endtask

  int          rv_k, rv_n, rdy_n, w1_n, w2_n;
  logic [63:0] wd;
  logic [4:0]  wa;
  logic        hit, emp;
  int          rv_ks[$];
  logic        rv_hs[$];
  int          acc_k, busy_rdy, acc_n;
  logic        acc;

  initial begin
    resetGeral = 1'b1; shot_valid = 1'b1; shot_player = 1'b1;
    shot_row = 5'd3; shot_col = 6'd9;

    // Reset with a pending shot: everything stays quiet.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_ctrl_outputs",
          64'({shot_ready, res_valid, res_hit, res_row_empty, readyColisor,
               jogadorColisor, colisor_addr, colisor_wrep1, colisor_wrep2}), 64'h0);
      chk("reset_data", colisor_data, 64'h0);
    end
    resetGeral = 1'b0; shot_valid = 1'b0;
    tick();
    chk("post_reset_ready", 64'(shot_ready), 64'h1);
    chk("post_reset_no_req", 64'(readyColisor), 64'h0);
`ifdef HIT_COUNT_EN
    chk("hits_p1_reset", 64'(hits_p1), 64'h0);
`endif

    // Hit on player one, row 4, column 5.
    run_shot(1'b0, 5'd4, 6'd5, rv_k, rv_n, rdy_n, w1_n, w2_n, wd, wa, hit, emp);
    chk("hit1_ready_cycles", 64'(rdy_n), 64'd5);
    chk("hit1_wrep1_cycles", 64'(w1_n), 64'd1);
    chk("hit1_wrep2_cycles", 64'(w2_n), 64'd0);
    chk("hit1_wdata", wd, 64'h0000_0000_0000_00D0);
    chk("hit1_waddr", 64'(wa), 64'd4);
    chk("hit1_res_cycle", 64'(rv_k), 64'd6);
    chk("hit1_res_count", 64'(rv_n), 64'd1);
    chk("hit1_res_hit", 64'(hit), 64'h1);
    chk("hit1_row_empty", 64'(emp), 64'h0);
    chk("hit1_mem", mem0[4], 64'h0000_0000_0000_00D0);

    // Same cell again: miss, no write.
    run_shot(1'b0, 5'd4, 6'd5, rv_k, rv_n, rdy_n, w1_n, w2_n, wd, wa, hit, emp);
    chk("miss_ready_cycles", 64'(rdy_n), 64'd4);
    chk("miss_wren_cycles", 64'(w1_n + w2_n), 64'd0);
    chk("miss_res_cycle", 64'(rv_k), 64'd5);
    chk("miss_res_hit", 64'(hit), 64'h0);
    chk("miss_row_empty", 64'(emp), 64'h0);
    chk("miss_mem", mem0[4], 64'h0000_0000_0000_00D0);

    // Player two, corner cell (31,63): full-width mask.
`ifdef HIT_COUNT_EN
    chk("hits_p2_before", 64'(hits_p2), 64'h0);
`endif
    run_shot(1'b1, 5'd31, 6'd63, rv_k, rv_n, rdy_n, w1_n, w2_n, wd, wa, hit, emp);
    chk("corner_wrep1_cycles", 64'(w1_n), 64'd0);
    chk("corner_wrep2_cycles", 64'(w2_n), 64'd1);
    chk("corner_wdata", wd, 64'h0);
    chk("corner_waddr", 64'(wa), 64'd31);
    chk("corner_res_cycle", 64'(rv_k), 64'd6);
    chk("corner_res_hit", 64'(hit), 64'h1);
    chk("corner_row_empty", 64'(emp), 64'h1);
    chk("corner_mem", mem1[31], 64'h0);
`ifdef HIT_COUNT_EN
    chk("hits_p2_after", 64'(hits_p2), 64'h1);
    chk("hits_p1_after", 64'(hits_p1), 64'h1);
`endif

    // Back-to-back: miss (0,4,5) then hit (1,0,0) held on the bus.
    wait_ready();
    shot_valid = 1'b1; shot_player = 1'b0; shot_row = 5'd4; shot_col = 6'd5;
    tick();
    shot_player = 1'b1; shot_row = 5'd0; shot_col = 6'd0;
    acc_k = -1; busy_rdy = 0; acc_n = 0;
    for (int k = 1; k <= 20; k++) begin
      if (res_valid) begin rv_ks.push_back(k); rv_hs.push_back(res_hit); end
      if (k <= 5 && shot_ready) busy_rdy++;
      acc = shot_ready && shot_valid;
      if (acc) begin acc_k = k; acc_n++; end
      tick();
      if (acc) shot_valid = 1'b0;
    end
    chk("b2b_ready_while_busy", 64'(busy_rdy), 64'd0);
    chk("b2b_accept_cycle", 64'(acc_k), 64'd6);
    chk("b2b_accept_count", 64'(acc_n), 64'd1);
    chk("b2b_res_count", 64'(rv_ks.size()), 64'd2);
    if (rv_ks.size() == 2) begin
      chk("b2b_res0_cycle", 64'(rv_ks[0]), 64'd5);
      chk("b2b_res0_hit", 64'(rv_hs[0]), 64'h0);
      chk("b2b_res1_cycle", 64'(rv_ks[1]), 64'd12);
      chk("b2b_res1_hit", 64'(rv_hs[1]), 64'h1);
    end
    chk("b2b_mem", mem1[0], 64'h0);

    // Reset asserted while the write strobe is up.
    wait_ready();
    shot_valid = 1'b1; shot_player = 1'b0; shot_row = 5'd7; shot_col = 6'd0;
    tick();
    shot_valid = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    chk("abort_in_write", 64'(colisor_wrep1), 64'h1);
    resetGeral = 1'b1;
    tick();
    chk("abort_wren_dropped", 64'({colisor_wrep1, colisor_wrep2}), 64'h0);
    chk("abort_no_result", 64'(res_valid), 64'h0);
    chk("abort_no_req", 64'(readyColisor), 64'h0);
    tick();
    resetGeral = 1'b0;
    rv_n = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (res_valid || colisor_wrep1 || colisor_wrep2) rv_n++;
    end
    chk("abort_quiet_after", 64'(rv_n), 64'd0);
    chk("abort_ready_again", 64'(shot_ready), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
